// File: rtl/inv_mix_col_iter.sv
// Iterative AES InvMixColumns: captures a 128-bit state and transforms
// COLS_PER_CYCLE columns per clock, with valid/ready on both sides.
module inv_mix_col_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("inv_mix_col_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

  state_t       state, state_nx;
  logic [1:0]   cnt;
  logic [0:127] work;
  logic [0:127] work_step;
  logic [0:127] out_q;
  logic         capture;
  logic         last;
  logic [1:0]   slot_col [COLS_PER_CYCLE];
  logic [31:0]  col_in   [COLS_PER_CYCLE];

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes a0..a3 occupy [31:24]..[7:0]; x2/x4/x8 are shared across the four products.
  function automatic logic [31:0] inv_col(input logic [31:0] a);
    logic [7:0] x1 [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int unsigned j = 0; j < 4; j++) begin
      x1[j] = a[31-8*j -: 8];
      x2[j] = xtime(x1[j]);
      x4[j] = xtime(x2[j]);
      x8[j] = xtime(x4[j]);
      m9[j] = x8[j] ^ x1[j];
      mb[j] = x8[j] ^ x2[j] ^ x1[j];
      md[j] = x8[j] ^ x4[j] ^ x1[j];
      me[j] = x8[j] ^ x4[j] ^ x2[j];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Only COLS_PER_CYCLE multipliers exist; they are steered onto the columns selected by cnt.
  always_comb begin
    work_step = work;
    for (int unsigned i = 0; i < COLS_PER_CYCLE; i++) begin
      slot_col[i] = cnt + 2'(i);
      col_in[i]   = work[32*slot_col[i] +: 32];
      work_step[32*slot_col[i] +: 32] = inv_col(col_in[i]);
    end
  end

  assign last = (({1'b0, cnt} + STEP) == 3'd4);

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture  = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            capture  = 1'b1;
            state_nx = BUSY;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      work  <= '0;
      out_q <= '0;
    end else begin
      state <= state_nx;
      if (capture) begin
        work <= in_data;
        cnt  <= '0;
      end else if (state == BUSY) begin
        work <= work_step;
        cnt  <= cnt + STEP[1:0];
        if (last) out_q <= work_step;
      end
    end
  end

  assign out_data = out_q;

endmodule

// File: tb/tb_inv_mix_col_iter.sv
// Self-checking bench: three instances (1, 2, 4 columns per cycle) against a
// GF(2^8) matrix reference model, including a MixColumns round trip.
module tb_inv_mix_col_iter;

  logic         clk;
  logic         rst_n     [3];
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [0:127] in_data   [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [0:127] out_data  [3];
  logic         busy      [3];

  int total = 0;
  int bad   = 0;

  localparam int NRT = 1000;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_mix_col_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: shift-and-add GF(2^8) multiply and generic circulant matrix product.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [0:127] mat(input logic [0:127] s, input logic [31:0] co);
    logic [0:127] r;
    logic [7:0]   acc, a, c;
    r = '0;
    for (int col = 0; col < 4; col++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          a   = s[32*col + 8*k +: 8];
          c   = co[31 - 8*((k - row) & 3) -: 8];
          acc = acc ^ gmul(a, c);
        end
        r[32*col + 8*row +: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [0:127] ref_inv(input logic [0:127] s);
    return mat(s, 32'h0e0b0d09);
  endfunction

  function automatic logic [0:127] ref_mix(input logic [0:127] s);
    return mat(s, 32'h02030101);
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int k);
    rst_n[k]     = 1'b0;
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b0;
    in_data[k]   = '0;
    tick();
    tick();
    rst_n[k] = 1'b1;
    #1;
  endtask

  task automatic accept(input int k, input logic [0:127] d, input string tag);
    int t;
    t = 0;
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    #1;
    while (!in_ready[k] && t < 50) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk({tag, "_in_ready"}, 128'(in_ready[k]), 128'(1));
    tick();
    in_valid[k] = 1'b0;
    in_data[k]  = rand128();
  endtask

  task automatic wait_out(input int k, output int lat, output int busyc);
    lat   = 0;
    busyc = 0;
    while (!out_valid[k] && lat < 20) begin
      if (busy[k]) busyc++;
      tick();
      lat++;
    end
  endtask

  task automatic handoff(input int k, input string tag);
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
    #1;
    chk({tag, "_post_ov"}, 128'(out_valid[k]), 128'(0));
    chk({tag, "_post_ir"}, 128'(in_ready[k]), 128'(1));
  endtask

  initial begin
    logic [0:127] v1, e1, v2, e2, r, held;
    logic [0:127] src_q [$];
    logic [0:127] obs;
    int n, lat, busyc, hv, hs, hr, sent, got, cyc;
    int hs_cyc [$];
    bit in_hs, out_hs;
    string pre;

    v1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    e1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    v2 = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    e2 = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b0; in_data[k] = '0;
    end

    for (int k = 0; k < 3; k++) begin
      n   = 4 >> k;
      pre = $sformatf("c%0d_", 1 << k);

      do_reset(k);
      chk({pre, "rst_ov"},   128'(out_valid[k]), 128'(0));
      chk({pre, "rst_od"},   out_data[k],        '0);
      chk({pre, "rst_busy"}, 128'(busy[k]),      128'(0));
      chk({pre, "rst_ir"},   128'(in_ready[k]),  128'(1));

      // Single block with latency and busy length.
      accept(k, v1, {pre, "blk1"});
      wait_out(k, lat, busyc);
      chk({pre, "blk1_lat"},  128'(lat),   128'(n));
      chk({pre, "blk1_busy"}, 128'(busyc), 128'(n));
      chk({pre, "blk1_data"}, out_data[k], e1);

      // Backpressure with a competing in_valid that must be ignored.
      held = out_data[k];
      r = rand128();
      in_valid[k] = 1'b1;
      in_data[k]  = rand128();
      hv = 0; hs = 0; hr = 0;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (out_valid[k]) hv++;
        if (out_data[k] === held) hs++;
        if (!in_ready[k]) hr++;
      end
      chk({pre, "bp_ov"},   128'(hv), 128'(10));
      chk({pre, "bp_od"},   128'(hs), 128'(10));
      chk({pre, "bp_ir"},   128'(hr), 128'(10));
      in_data[k]   = r;
      out_ready[k] = 1'b1;
      #1;
      chk({pre, "bp_ir_pass"}, 128'(in_ready[k]), 128'(1));
      tick();
      out_ready[k] = 1'b0;
      in_valid[k]  = 1'b0;
      in_data[k]   = rand128();
      chk({pre, "bp_cap_ov"},   128'(out_valid[k]), 128'(0));
      chk({pre, "bp_cap_busy"}, 128'(busy[k]),      128'(1));
      wait_out(k, lat, busyc);
      chk({pre, "bp_lat"},  128'(lat),   128'(n));
      chk({pre, "bp_data"}, out_data[k], ref_inv(r));
      handoff(k, {pre, "bp"});

      // Column vectors.
      accept(k, v2, {pre, "colv"});
      wait_out(k, lat, busyc);
      chk({pre, "colv_lat"},  128'(lat),   128'(n));
      chk({pre, "colv_data"}, out_data[k], e2);
      handoff(k, {pre, "colv"});

      // Asynchronous reset one cycle into BUSY.
      accept(k, rand128(), {pre, "rstb"});
      tick();
      #2;
      rst_n[k] = 1'b0;
      #1;
      chk({pre, "arst_ov"},   128'(out_valid[k]), 128'(0));
      chk({pre, "arst_od"},   out_data[k],        '0);
      chk({pre, "arst_busy"}, 128'(busy[k]),      128'(0));
      chk({pre, "arst_ir"},   128'(in_ready[k]),  128'(1));
      @(negedge clk);
      rst_n[k] = 1'b1;
      tick();
      r = rand128();
      accept(k, r, {pre, "post_rst"});
      wait_out(k, lat, busyc);
      chk({pre, "post_rst_lat"},  128'(lat),   128'(n));
      chk({pre, "post_rst_data"}, out_data[k], ref_inv(r));
      handoff(k, {pre, "post_rst"});

      // Back-to-back throughput with out_ready held high.
      hs_cyc.delete();
      in_valid[k]  = 1'b1;
      out_ready[k] = 1'b1;
      for (int c = 0; c < 24; c++) begin
        in_data[k] = rand128();
        #1;
        if (out_valid[k] && out_ready[k]) hs_cyc.push_back(c);
        tick();
      end
      in_valid[k] = 1'b0;
      chk({pre, "tput_cnt"}, 128'(hs_cyc.size() >= 3), 128'(1));
      if (hs_cyc.size() >= 3) begin
        chk({pre, "tput_gap1"}, 128'(hs_cyc[1] - hs_cyc[0]), 128'(n + 1));
        chk({pre, "tput_gap2"}, 128'(hs_cyc[2] - hs_cyc[1]), 128'(n + 1));
      end
      do_reset(k);

      // Round trip through forward MixColumns with random stalls on both sides.
      src_q.delete();
      sent = 0; got = 0; cyc = 0;
      while (got < NRT && cyc < 20000) begin
        out_ready[k] = 1'($urandom_range(0, 1));
        if (!in_valid[k] && sent < NRT && $urandom_range(0, 3) != 0) begin
          r = rand128();
          src_q.push_back(r);
          in_data[k]  = ref_mix(r);
          in_valid[k] = 1'b1;
        end
        #1;
        in_hs  = in_valid[k] && in_ready[k];
        out_hs = out_valid[k] && out_ready[k];
        obs    = out_data[k];
        tick();
        if (in_hs) begin
          in_valid[k] = 1'b0;
          in_data[k]  = rand128();
          sent++;
        end
        if (out_hs) begin
          if (src_q.size() == 0) chk({pre, "rt_extra"}, 128'(src_q.size()), 128'(1));
          else chk({pre, "rt_data"}, obs, src_q.pop_front());
          got++;
        end
        cyc++;
      end
      out_ready[k] = 1'b0;
      chk({pre, "rt_count"}, 128'(got), 128'(NRT));
      chk({pre, "rt_sent"},  128'(sent), 128'(NRT));
      repeat (6) tick();
      chk({pre, "rt_idle_ov"}, 128'(out_valid[k]), 128'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
